// File: rtl/mem_bank_pkg.sv
// Shared types and address decode for the handshaked memory bank controller.
// Regions: user RAM, system RAM, an I/O window, or unmapped space.
`timescale 1ns/1ps
package mem_bank_pkg;

    typedef enum logic [1:0] {IDLE, MEM, IO_WAIT, RESP} state_e;
    typedef enum logic [1:0] {REG_NONE, REG_USER, REG_SYS, REG_IO} region_e;

    localparam logic [31:0] DEF_USER_WORDS    = 32'd8192;
    localparam logic [31:0] DEF_SYS_BASE_WORD = 32'h0000_5000;
    localparam logic [31:0] DEF_SYS_WORDS     = 32'd3072;
    localparam logic [31:0] DEF_IO_BASE       = 32'h1000_0000;

    // Misalignment beats everything; SYS is tested before USER so it wins any overlap.
    function automatic region_e decode(input logic [31:0] addr,
                                       input logic [31:0] io_base,
                                       input logic [31:0] sys_base_word,
                                       input logic [31:0] sys_words,
                                       input logic [31:0] user_words);
        logic [32:0] word;
        logic [32:0] sys_end;
        region_e     region;
        word    = {3'b000, addr[31:2]};
        sys_end = {1'b0, sys_base_word} + {1'b0, sys_words};
        region  = REG_NONE;
        if (addr[1:0] != 2'b00)
            region = REG_NONE;
        else if (addr >= io_base)
            region = REG_IO;
        else if (word >= {1'b0, sys_base_word} && word < sys_end)
            region = REG_SYS;
        else if (word < {1'b0, user_words})
            region = REG_USER;
        return region;
    endfunction

endpackage

// File: rtl/mem_bank_ram.sv
// Single-port synchronous RAM with byte-lane write enables and a registered
// read port (one-cycle read, read-before-write on a same-address collision).
`timescale 1ns/1ps
module mem_bank_ram #(
    parameter int WORDS  = 1024,
    parameter int DATA_W = 32,
    parameter int AW     = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [AW-1:0]         addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     q
);

    logic [DATA_W-1:0] mem [WORDS];

    // NOTE: the storage array has no reset; clearing it would force a flop-based implementation.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (be[b])
                    mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/mem_bank_ctrl.sv
// Request/acknowledge memory bank controller: decodes a byte address into
// user RAM, system RAM or an I/O window, with exactly one RAM write per request.
`timescale 1ns/1ps
module mem_bank_ctrl
    import mem_bank_pkg::*;
#(
    parameter int          DATA_W        = 32,
    parameter int          USER_WORDS    = 8192,
    parameter logic [31:0] SYS_BASE_WORD = DEF_SYS_BASE_WORD,
    parameter int          SYS_WORDS     = 3072,
    parameter logic [31:0] IO_BASE       = DEF_IO_BASE,
    parameter int          RD_LAT        = 1,
    parameter int          IO_TIMEOUT    = 255,
    parameter int          BE_W          = DATA_W / 8
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iReq,
    input  logic              iWrite,
    input  logic [31:0]       iAddress,
    input  logic [BE_W-1:0]   iByteEnable,
    input  logic [DATA_W-1:0] iWriteData,
    output logic              oBusy,
    output logic              oAck,
    output logic              oErr,
    output logic [DATA_W-1:0] oMemData,
    output logic              oIOReq,
    output logic              oIOWrite,
    output logic [31:0]       oIOAddress,
    output logic [BE_W-1:0]   oIOByteEnable,
    output logic [DATA_W-1:0] oIOWriteData,
    input  logic              iIOAck,
    input  logic [DATA_W-1:0] iIOData
);

    localparam int UA_W       = (USER_WORDS > 1) ? $clog2(USER_WORDS) : 1;
    localparam int SA_W       = (SYS_WORDS > 1) ? $clog2(SYS_WORDS) : 1;
    localparam int CNT_W      = (IO_TIMEOUT > 0) ? $clog2(IO_TIMEOUT + 1) : 1;
    localparam int IO_TO_LAST = (IO_TIMEOUT > 0) ? IO_TIMEOUT - 1 : 0;

    state_e            state, state_n;
    region_e           region_q, region_in;
    logic              write_q;
    logic [31:0]       addr_q;
    logic [BE_W-1:0]   be_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        mem_cnt;
    logic [CNT_W-1:0]  io_cnt;
    logic              err_q, err_n;
    logic              ld_data;
    logic [DATA_W-1:0] data_n;
    logic [DATA_W-1:0] rdata_q;

    logic              mem_first, mem_last, io_timeout;
    logic              user_we, sys_we;
    logic [31:0]       ram_addr;
    logic [UA_W-1:0]   user_idx;
    logic [SA_W-1:0]   sys_idx;
    logic [DATA_W-1:0] user_q, sys_q, ram_q, rd_data;

    assign region_in  = decode(iAddress, IO_BASE, SYS_BASE_WORD, 32'(SYS_WORDS), 32'(USER_WORDS));
    assign mem_first  = (state == MEM) && (mem_cnt == 2'd0);
    assign mem_last   = (state == MEM) && (mem_cnt == 2'(RD_LAT - 1));
    assign io_timeout = (io_cnt == CNT_W'(IO_TO_LAST));

    // The write strobe lives only in the first MEM cycle and is killed by a coincident reset.
    assign user_we = mem_first && write_q && (region_q == REG_USER) && !iRST;
    assign sys_we  = mem_first && write_q && (region_q == REG_SYS) && !iRST;

    // Read is launched on the acceptance edge so RAM q is ready by the end of the first MEM cycle.
    assign ram_addr = (state == IDLE) ? iAddress : addr_q;
    assign user_idx = ram_addr[UA_W+1:2];
    assign sys_idx  = SA_W'(ram_addr[31:2] - SYS_BASE_WORD[29:0]);
    assign ram_q    = (region_q == REG_SYS) ? sys_q : user_q;

    mem_bank_ram #(.WORDS(USER_WORDS), .DATA_W(DATA_W)) u_user_ram (
        .clk   (iCLK),
        .we    (user_we),
        .be    (be_q),
        .addr  (user_idx),
        .wdata (wdata_q),
        .q     (user_q)
    );

    mem_bank_ram #(.WORDS(SYS_WORDS), .DATA_W(DATA_W)) u_sys_ram (
        .clk   (iCLK),
        .we    (sys_we),
        .be    (be_q),
        .addr  (sys_idx),
        .wdata (wdata_q),
        .q     (sys_q)
    );

    // Extra read latency beyond the RAM's own cycle is absorbed by a data pipeline.
    generate
        if (RD_LAT > 1) begin : g_pipe
            logic [DATA_W-1:0] pipe [RD_LAT-1];
            always_ff @(posedge iCLK) begin
                pipe[0] <= ram_q;
                for (int i = 1; i < RD_LAT - 1; i++)
                    pipe[i] <= pipe[i-1];
            end
            assign rd_data = pipe[RD_LAT-2];
        end else begin : g_nopipe
            assign rd_data = ram_q;
        end
    endgenerate

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_n = state;
        err_n   = 1'b0;
        ld_data = 1'b0;
        data_n  = '0;
        unique case (state)
            IDLE: begin
                if (iReq) begin
                    unique case (region_in)
                        REG_USER, REG_SYS: state_n = MEM;
                        REG_IO:            state_n = IO_WAIT;
                        default: begin
                            state_n = RESP;
                            err_n   = 1'b1;
                            ld_data = 1'b1;
                        end
                    endcase
                end
            end
            MEM: begin
                if (mem_last) begin
                    state_n = RESP;
                    ld_data = !write_q;
                    data_n  = rd_data;
                end
            end
            IO_WAIT: begin
                if (iIOAck) begin
                    state_n = RESP;
                    ld_data = !write_q;
                    data_n  = iIOData;
                end else if (io_timeout) begin
                    state_n = RESP;
                    err_n   = 1'b1;
                    ld_data = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block rather than in the sensitivity list.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state    <= IDLE;
            region_q <= REG_NONE;
            write_q  <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            wdata_q  <= '0;
            mem_cnt  <= '0;
            io_cnt   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && iReq) begin
                region_q <= region_in;
                write_q  <= iWrite;
                addr_q   <= iAddress;
                be_q     <= iByteEnable;
                wdata_q  <= iWriteData;
            end
            mem_cnt <= (state == MEM) ? mem_cnt + 2'd1 : 2'd0;
            if (state != IO_WAIT)
                io_cnt <= '0;
            else if (io_cnt != CNT_W'(IO_TIMEOUT))
                io_cnt <= io_cnt + 1'b1;
            err_q <= (state_n == RESP) ? err_n : 1'b0;
            if (ld_data)
                rdata_q <= data_n;
        end
    end

    assign oBusy         = (state != IDLE);
    assign oAck          = (state == RESP);
    assign oErr          = err_q;
    assign oMemData      = rdata_q;
    assign oIOReq        = (state == IO_WAIT);
    assign oIOWrite      = write_q;
    assign oIOAddress    = addr_q;
    assign oIOByteEnable = be_q;
    assign oIOWriteData  = wdata_q;

endmodule

// File: tb/tb_mem_bank_ctrl.sv
// Directed bench for mem_bank_ctrl: RAM, byte-lane, unmapped, I/O, timeout and reset cases,
// plus a second instance with three-cycle RAM latency.
`timescale 1ns/1ps
module tb_mem_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req1 = 1'b0, req3 = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        io_ack = 1'b0;
    logic [31:0] io_data = '0;

    logic        busy1, ack1, err1, ioreq1, iowr1;
    logic [31:0] mdata1, ioaddr1, iowdata1;
    logic [3:0]  iobe1;
    logic        busy3, ack3, err3, ioreq3, iowr3;
    logic [31:0] mdata3, ioaddr3, iowdata3;
    logic [3:0]  iobe3;

    int compared   = 0;
    int mismatched = 0;
    int strobes    = 0;

    always #5 clk = ~clk;

    mem_bank_ctrl #(.RD_LAT(1), .IO_TIMEOUT(8)) dut (
        .iCLK(clk), .iRST(rst), .iReq(req1), .iWrite(wr), .iAddress(addr),
        .iByteEnable(be), .iWriteData(wdata),
        .oBusy(busy1), .oAck(ack1), .oErr(err1), .oMemData(mdata1),
        .oIOReq(ioreq1), .oIOWrite(iowr1), .oIOAddress(ioaddr1),
        .oIOByteEnable(iobe1), .oIOWriteData(iowdata1),
        .iIOAck(io_ack), .iIOData(io_data)
    );

    mem_bank_ctrl #(.RD_LAT(3), .IO_TIMEOUT(8)) dut3 (
        .iCLK(clk), .iRST(rst), .iReq(req3), .iWrite(wr), .iAddress(addr),
        .iByteEnable(be), .iWriteData(wdata),
        .oBusy(busy3), .oAck(ack3), .oErr(err3), .oMemData(mdata3),
        .oIOReq(ioreq3), .oIOWrite(iowr3), .oIOAddress(ioaddr3),
        .oIOByteEnable(iobe3), .oIOWriteData(iowdata3),
        .iIOAck(io_ack), .iIOData(io_data)
    );

    // RAM write strobes of the main instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (dut.user_we || dut.sys_we)
            strobes++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request; returns #1 after the acceptance edge T.
    task automatic issue(input bit sel3, input bit w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
        @(negedge clk);
        wr = w; addr = a; be = b; wdata = d;
        if (sel3) req3 = 1'b1; else req1 = 1'b1;
        @(posedge clk);
        #1;
        req1 = 1'b0; req3 = 1'b0;
    endtask

    // Latency = index of the edge after T at which oAck would be sampled high; -1 if never.
    task automatic wait_ack(input bit sel3, input int max_cyc, output int lat);
        int cyc;
        cyc = 1;
        while (!(sel3 ? ack3 : ack1) && cyc < max_cyc) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        lat = (sel3 ? ack3 : ack1) ? cyc : -1;
    endtask

    task automatic end_txn(input bit sel3, input string tag);
        @(posedge clk);
        #1;
        check({tag, "_ack_drop"}, 32'(sel3 ? ack3 : ack1), 32'd0);
        check({tag, "_idle"}, 32'(sel3 ? busy3 : busy1), 32'd0);
    endtask

    initial begin
        int lat;
        int s0;
        int iocnt;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_ack", 32'(ack1), 32'd0);
        check("rst_err", 32'(err1), 32'd0);
        check("rst_ioreq", 32'(ioreq1), 32'd0);
        check("rst_mdata", mdata1, 32'd0);
        check("rst_ioaddr", ioaddr1, 32'd0);
        rst = 1'b0;

        // Full-word write then readback at user word 4.
        s0 = strobes;
        issue(0, 1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
        wait_ack(0, 10, lat);
        check("wr10_lat", 32'(lat), 32'd2);
        check("wr10_err", 32'(err1), 32'd0);
        end_txn(0, "wr10");
        check("wr10_strobes", 32'(strobes - s0), 32'd1);

        issue(0, 0, 32'h0000_0010, 4'hF, 32'h0);
        wait_ack(0, 10, lat);
        check("rd10_lat", 32'(lat), 32'd2);
        check("rd10_err", 32'(err1), 32'd0);
        check("rd10_data", mdata1, 32'hDEAD_BEEF);
        end_txn(0, "rd10");

        // A write leaves oMemData unchanged; also seeds word 0x20 for the reset test.
        issue(0, 1, 32'h0000_0020, 4'hF, 32'h0BAD_F00D);
        wait_ack(0, 10, lat);
        check("wr20_data_kept", mdata1, 32'hDEAD_BEEF);
        end_txn(0, "wr20");

        issue(0, 1, 32'h0000_0000, 4'hF, 32'hCAFE_F00D);
        wait_ack(0, 10, lat);
        end_txn(0, "wr0");

        // Byte-lane write into system RAM word 0x5000.
        issue(0, 1, 32'h0001_4000, 4'hF, 32'h1122_3344);
        wait_ack(0, 10, lat);
        end_txn(0, "wrsys_full");
        issue(0, 1, 32'h0001_4000, 4'b0100, 32'hAABB_CCDD);
        wait_ack(0, 10, lat);
        check("wrsys_lane_err", 32'(err1), 32'd0);
        end_txn(0, "wrsys_lane");
        issue(0, 0, 32'h0001_4000, 4'hF, 32'h0);
        wait_ack(0, 10, lat);
        check("rdsys_data", mdata1, 32'h11BB_3344);
        end_txn(0, "rdsys");
        issue(0, 0, 32'h0000_0000, 4'hF, 32'h0);
        wait_ack(0, 10, lat);
        check("rd0_unchanged", mdata1, 32'hCAFE_F00D);
        end_txn(0, "rd0");

        // Unmapped and misaligned reads.
        s0 = strobes;
        issue(0, 0, 32'h0001_0000, 4'hF, 32'h0);
        wait_ack(0, 10, lat);
        check("unmap_lat", 32'(lat), 32'd1);
        check("unmap_err", 32'(err1), 32'd1);
        check("unmap_data", mdata1, 32'd0);
        end_txn(0, "unmap");
        issue(0, 0, 32'h0000_0010, 4'hF, 32'h0);
        wait_ack(0, 10, lat);
        end_txn(0, "reload");
        issue(0, 0, 32'h0000_0002, 4'hF, 32'h0);
        wait_ack(0, 10, lat);
        check("misal_lat", 32'(lat), 32'd1);
        check("misal_err", 32'(err1), 32'd1);
        check("misal_data", mdata1, 32'd0);
        end_txn(0, "misal");
        check("bad_strobes", 32'(strobes - s0), 32'd0);

        // I/O read acknowledged in the fifth request cycle.
        issue(0, 0, 32'h1000_0004, 4'hF, 32'h0);
        iocnt = 0;
        repeat (4) begin
            if (ioreq1) iocnt++;
            @(posedge clk);
            #1;
        end
        if (ioreq1) iocnt++;
        check("io_addr", ioaddr1, 32'h1000_0004);
        check("io_wr", 32'(iowr1), 32'd0);
        io_ack = 1'b1; io_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        io_ack = 1'b0; io_data = '0;
        check("io_req_cycles", 32'(iocnt), 32'd5);
        check("io_ack", 32'(ack1), 32'd1);
        check("io_err", 32'(err1), 32'd0);
        check("io_data", mdata1, 32'h1234_5678);
        check("io_req_drop", 32'(ioreq1), 32'd0);
        end_txn(0, "io");

        // No device response: timeout error.
        issue(0, 0, 32'h1000_0008, 4'hF, 32'h0);
        wait_ack(0, 20, lat);
        check("to_lat", 32'(lat), 32'd9);
        check("to_err", 32'(err1), 32'd1);
        check("to_data", mdata1, 32'd0);
        check("to_req_drop", 32'(ioreq1), 32'd0);
        end_txn(0, "to");

        // Ack in the same cycle as the timeout wins.
        issue(0, 0, 32'h1000_0008, 4'hF, 32'h0);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        check("race_no_early_ack", 32'(ack1), 32'd0);
        io_ack = 1'b1; io_data = 32'h0000_A5A5;
        @(posedge clk);
        #1;
        io_ack = 1'b0; io_data = '0;
        check("race_ack", 32'(ack1), 32'd1);
        check("race_err", 32'(err1), 32'd0);
        check("race_data", mdata1, 32'h0000_A5A5);
        end_txn(0, "race");

        // Reset in the first MEM cycle of a write suppresses the strobe.
        s0 = strobes;
        issue(0, 1, 32'h0000_0020, 4'hF, 32'h5555_5555);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rstmem_busy", 32'(busy1), 32'd0);
        check("rstmem_ack", 32'(ack1), 32'd0);
        check("rstmem_err", 32'(err1), 32'd0);
        check("rstmem_mdata", mdata1, 32'd0);
        check("rstmem_ioaddr", ioaddr1, 32'd0);
        check("rstmem_strobes", 32'(strobes - s0), 32'd0);
        issue(0, 0, 32'h0000_0020, 4'hF, 32'h0);
        wait_ack(0, 10, lat);
        check("rstmem_readback", mdata1, 32'h0BAD_F00D);
        end_txn(0, "rstmem");

        // Three-cycle RAM latency instance.
        issue(1, 1, 32'h0000_0040, 4'hF, 32'h1357_9BDF);
        wait_ack(1, 10, lat);
        check("lat3_wr_lat", 32'(lat), 32'd4);
        check("lat3_wr_err", 32'(err3), 32'd0);
        end_txn(1, "lat3_wr");
        issue(1, 0, 32'h0000_0040, 4'hF, 32'h0);
        wait_ack(1, 10, lat);
        check("lat3_rd_lat", 32'(lat), 32'd4);
        check("lat3_rd_data", mdata3, 32'h1357_9BDF);
        end_txn(1, "lat3_rd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
